// File: rtl/seg_scan_mux.sv
// Five-digit 7-segment scan multiplexer: snapshots digit patterns on request and
// time-multiplexes them onto one segment bus with a blanking gap per slot.
//
// state   | meaning
// S_BLANK | start of slot (or display disabled): anodes off, bus at OFF
// S_ON    | remainder of slot: anode idx lit, bus holds snapshot[idx]
module seg_scan_mux #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [6:0] i_Seg_first,
    input  logic [6:0] i_Seg_second,
    input  logic [6:0] i_Seg_third,
    input  logic [6:0] i_Seg_fourth,
    input  logic [6:0] i_Seg_fifth,
    input  logic       i_Capture,
    input  logic       i_Enable,
    output logic [6:0] o_Seg,
    output logic [4:0] o_An,
    output logic [2:0] o_Digit_idx,
    output logic       o_Frame
);

    localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam int unsigned   CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYCLES);

    typedef enum logic {S_BLANK, S_ON} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic          paused;
    logic [6:0]    snap [5];

    function automatic logic [6:0] slot_seg(input logic [2:0] k);
        case (k)
            3'd0:    slot_seg = snap[0];
            3'd1:    slot_seg = snap[1];
            3'd2:    slot_seg = snap[2];
            3'd3:    slot_seg = snap[3];
            3'd4:    slot_seg = snap[4];
            default: slot_seg = SEG_OFF;
        endcase
    endfunction

    function automatic logic [4:0] slot_an(input logic [2:0] k);
        case (k)
            3'd0:    slot_an = 5'b11110;
            3'd1:    slot_an = 5'b11101;
            3'd2:    slot_an = 5'b11011;
            3'd3:    slot_an = 5'b10111;
            3'd4:    slot_an = 5'b01111;
            default: slot_an = 5'b11111;
        endcase
    endfunction

    assign idx_next = (idx == 3'd4) ? 3'd0 : idx + 3'd1;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            snap[0]     <= SEG_OFF;
            snap[1]     <= SEG_OFF;
            snap[2]     <= SEG_OFF;
            snap[3]     <= SEG_OFF;
            snap[4]     <= SEG_OFF;
            state       <= S_BLANK;
            cnt         <= '0;
            idx         <= 3'd0;
            paused      <= 1'b0;
            o_Seg       <= SEG_OFF;
            o_An        <= 5'b11111;
            o_Digit_idx <= 3'd0;
            o_Frame     <= 1'b0;
        end else begin
            // Display reads use the pre-edge snapshot, so a coincident capture shows next visit.
            if (i_Capture) begin
                snap[0] <= i_Seg_first;
                snap[1] <= i_Seg_second;
                snap[2] <= i_Seg_third;
                snap[3] <= i_Seg_fourth;
                snap[4] <= i_Seg_fifth;
            end
            o_Frame <= 1'b0;

            if (!i_Enable) begin
                paused <= 1'b1;
                state  <= S_BLANK;
                o_An   <= 5'b11111;
                o_Seg  <= SEG_OFF;
            end else if (paused) begin
                paused <= 1'b0;
                cnt    <= '0;
                if (BLANK_CYCLES == 0) begin
                    state <= S_ON;
                    o_An  <= slot_an(idx);
                    o_Seg <= slot_seg(idx);
                end else begin
                    state <= S_BLANK;
                end
            end else if (cnt == CNT_LAST) begin
                cnt         <= '0;
                idx         <= idx_next;
                o_Digit_idx <= idx_next;
                o_Frame     <= (idx == 3'd4);
                if (BLANK_CYCLES == 0) begin
                    state <= S_ON;
                    o_An  <= slot_an(idx_next);
                    o_Seg <= slot_seg(idx_next);
                end else begin
                    state <= S_BLANK;
                    o_An  <= 5'b11111;
                    o_Seg <= SEG_OFF;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (state == S_BLANK && (cnt + 1'b1) == CNT_ON) begin
                    state <= S_ON;
                    o_An  <= slot_an(idx);
                    o_Seg <= slot_seg(idx);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized bench for seg_scan_mux: two configurations driven in parallel and
// compared every cycle against a slot-position reference model.
module tb_seg_scan_mux;

    localparam int DIV = 8;

    logic       i_Clk = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic [6:0] seg_in [5];
    logic       i_Capture = 1'b0;
    logic       i_Enable = 1'b1;

    logic [6:0] seg0, seg1;
    logic [4:0] an0, an1;
    logic [2:0] idx0, idx1;
    logic       frame0, frame1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_Clk = ~i_Clk;

    seg_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)) u_dut0 (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n),
        .i_Seg_first(seg_in[0]), .i_Seg_second(seg_in[1]), .i_Seg_third(seg_in[2]),
        .i_Seg_fourth(seg_in[3]), .i_Seg_fifth(seg_in[4]),
        .i_Capture(i_Capture), .i_Enable(i_Enable),
        .o_Seg(seg0), .o_An(an0), .o_Digit_idx(idx0), .o_Frame(frame0)
    );

    seg_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b0)) u_dut1 (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n),
        .i_Seg_first(seg_in[0]), .i_Seg_second(seg_in[1]), .i_Seg_third(seg_in[2]),
        .i_Seg_fourth(seg_in[3]), .i_Seg_fifth(seg_in[4]),
        .i_Capture(i_Capture), .i_Enable(i_Enable),
        .o_Seg(seg1), .o_An(an1), .o_Digit_idx(idx1), .o_Frame(frame1)
    );

    // Reference model: position within slot, lit predicate, value latched when lighting.
    int m_blank [2] = '{2, 0};
    int m_off   [2] = '{127, 0};
    int m_pos [2], m_idx [2], m_shown [2];
    bit m_paused [2], m_dark [2], m_frame [2], m_lit [2];
    int m_snap [2][5];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pos[c] = 0; m_idx[c] = 0; m_paused[c] = 0; m_dark[c] = 1;
            m_frame[c] = 0; m_lit[c] = 0; m_shown[c] = m_off[c];
            for (int k = 0; k < 5; k++) m_snap[c][k] = m_off[c];
        end
    endtask

    task automatic model_edge(input int c);
        m_frame[c] = 0;
        if (!i_Enable) begin
            m_paused[c] = 1;
        end else if (m_paused[c]) begin
            m_paused[c] = 0; m_pos[c] = 0; m_dark[c] = 0;
        end else if (m_pos[c] == DIV - 1) begin
            m_pos[c] = 0;
            m_frame[c] = (m_idx[c] == 4);
            m_idx[c] = (m_idx[c] + 1) % 5;
            m_dark[c] = 0;
        end else begin
            m_pos[c]++;
        end
        m_lit[c] = i_Enable && !(m_dark[c] && m_blank[c] == 0) && (m_pos[c] >= m_blank[c]);
        if (m_lit[c] && m_pos[c] == m_blank[c]) m_shown[c] = m_snap[c][m_idx[c]];
        if (i_Capture) for (int k = 0; k < 5; k++) m_snap[c][k] = int'(seg_in[k]);
    endtask

    function automatic int exp_an(input int c);
        return m_lit[c] ? (31 & ~(1 << m_idx[c])) : 31;
    endfunction

    function automatic int exp_seg(input int c);
        return m_lit[c] ? m_shown[c] : m_off[c];
    endfunction

    task automatic compare_all();
        chk("an0", int'(an0), exp_an(0));
        chk("seg0", int'(seg0), exp_seg(0));
        chk("idx0", int'(idx0), m_idx[0]);
        chk("frame0", int'(frame0), int'(m_frame[0]));
        chk("an1", int'(an1), exp_an(1));
        chk("seg1", int'(seg1), exp_seg(1));
        chk("idx1", int'(idx1), m_idx[1]);
        chk("frame1", int'(frame1), int'(m_frame[1]));
    endtask

    task automatic tick();
        @(posedge i_Clk);
        if (i_Rst_n) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        compare_all();
    endtask

    // Called at posedge+1: asserts reset between edges and checks it takes hold at once.
    task automatic do_reset();
        #2;
        i_Rst_n = 1'b0;
        #1;
        chk("rst_an0", int'(an0), 31);
        chk("rst_seg0", int'(seg0), 'h7F);
        chk("rst_idx0", int'(idx0), 0);
        chk("rst_frame0", int'(frame0), 0);
        chk("rst_seg1", int'(seg1), 'h00);
        chk("rst_an1", int'(an1), 31);
        model_reset();
        repeat (2) @(posedge i_Clk);
        #1;
        i_Rst_n = 1'b1;
    endtask

    task automatic set_inputs(input int a, input int b, input int c, input int d, input int e);
        seg_in[0] = 7'(a); seg_in[1] = 7'(b); seg_in[2] = 7'(c);
        seg_in[3] = 7'(d); seg_in[4] = 7'(e);
    endtask

    initial begin
        bit found;
        model_reset();
        set_inputs(0, 0, 0, 0, 0);
        repeat (2) @(posedge i_Clk);
        #1;
        compare_all();

        // Scan order with patterns 01..05 captured on the first edge after release.
        set_inputs(1, 2, 3, 4, 5);
        i_Capture = 1'b1;
        i_Rst_n = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            i_Capture = 1'b0;
            if (k == 1)  chk("blank_c1_an", int'(an0), 5'b11111);
            if (k == 2)  chk("slot0_an", int'(an0), 5'b11110);
            if (k == 2)  chk("slot0_seg", int'(seg0), 'h01);
            if (k == 10) chk("slot1_seg", int'(seg0), 'h02);
            if (k == 34) chk("slot4_an", int'(an0), 5'b01111);
            if (k == 34) chk("slot4_seg", int'(seg0), 'h05);
            if (k == 40) chk("wrap_frame", int'(frame0), 1);
            if (k == 40) chk("wrap_idx", int'(idx0), 0);
            if (k == 41) chk("frame_once", int'(frame0), 0);
        end

        // Uncaptured inputs must never reach the bus.
        set_inputs('h40, 'h40, 'h40, 'h40, 'h40);
        for (int k = 0; k < 100; k++) begin
            tick();
            chk("iso_seg", int'((seg0 >= 7'h01 && seg0 <= 7'h05) || seg0 == 7'h7F), 1);
        end

        // Reset mid-ON at idx 3.
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            found = (m_idx[0] == 3 && m_pos[0] == 4);
        end
        chk("wait_idx3", int'(found), 1);
        do_reset();
        set_inputs(1, 2, 3, 4, 5);
        i_Capture = 1'b1;
        tick();
        i_Capture = 1'b0;
        tick();
        chk("rst_first_on", int'(an0), 5'b11110);

        // Enable drop at idx 2, cnt 4, for 10 cycles.
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            found = (m_idx[0] == 2 && m_pos[0] == 4);
        end
        chk("wait_idx2", int'(found), 1);
        i_Enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) chk("dis_an", int'(an0), 5'b11111);
            if (k == 1) chk("dis_seg", int'(seg0), 'h7F);
        end
        i_Enable = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) chk("resume_blank", int'(an0), 5'b11111);
            if (k == 3) chk("resume_on_an", int'(an0), 5'b11011);
            if (k == 8) chk("resume_on_seg", int'(seg0), 'h03);
        end

        // Capture coincident with the idx-0 BLANK->ON edge.
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            found = (m_idx[0] == 0 && m_pos[0] == 1);
        end
        chk("wait_race", int'(found), 1);
        set_inputs('h0F, 2, 3, 4, 5);
        i_Capture = 1'b1;
        tick();
        i_Capture = 1'b0;
        chk("race_old", int'(seg0), 'h01);
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            found = (m_idx[0] == 0 && m_pos[0] == 2);
        end
        chk("wait_race2", int'(found), 1);
        chk("race_new", int'(seg0), 'h0F);

        // Randomized traffic with occasional disables and resets.
        for (int k = 0; k < 1500; k++) begin
            if (k == 700 || k == 1200) do_reset();
            i_Capture = ($urandom_range(0, 15) == 0);
            for (int d = 0; d < 5; d++) seg_in[d] = 7'($urandom);
            if ($urandom_range(0, 63) == 0) i_Enable = ~i_Enable;
            tick();
        end
        i_Enable = 1'b1;
        i_Capture = 1'b0;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Display back-end stage directly downstream of the single-cycle datapath top.
- Consumes the five 7-segment digit patterns produced by the instruction decoder.
- Snapshots them on request and time-multiplexes them onto one shared segment bus with five anode enables.
- Inserts a blanking gap between digits to suppress ghosting, and emits a frame pulse per full scan.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (blank + on); must be >= 2 and > BLANK_CYCLES.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; 0 disables blanking.
- SEG_ACTIVE_LOW, 1, 1: segment patterns are active-low and the off value is 7'h7F; 0: active-high and the off value is 7'h00.

Ports:
- i_Clk  input  1  system clock.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Seg_first  input  7  digit 0 pattern.
- i_Seg_second  input  7  digit 1 pattern.
- i_Seg_third  input  7  digit 2 pattern.
- i_Seg_fourth  input  7  digit 3 pattern.
- i_Seg_fifth  input  7  digit 4 pattern.
- i_Capture  input  1  high on a rising edge loads all five patterns into the snapshot registers.
- i_Enable  input  1  display enable; low blanks the display and freezes the scan.
- o_Seg  output  7  shared segment bus (registered).
- o_An  output  5  anode enables, active-low, one-hot-low when lit (registered).
- o_Digit_idx  output  3  index of the current slot, 0..4.
- o_Frame  output  1  one-cycle pulse when the index wraps 4->0.

Behaviour:
- One clock domain; reset is asynchronous and active-low. Assertion takes effect immediately, mid-operation included.
- Reset values:
  - snapshots = OFF; cnt = 0; idx = 0; state = BLANK.
  - o_An = 5'b11111; o_Seg = OFF; o_Digit_idx = 0; o_Frame = 0.
  - OFF = 7'h7F if SEG_ACTIVE_LOW else 7'h00.
- Snapshot:
  - On a rising edge with i_Capture=1, all five snapshot registers load together.
  - Inputs are otherwise ignored; changing inputs without a capture never alters the display.
- Digit mapping: idx k drives snapshot k and o_An bit k low (first = bit 0).
- Counter: cnt counts 0..REFRESH_DIV-1 per slot. At cnt == REFRESH_DIV-1: cnt -> 0, idx -> (idx==4 ? 0 : idx+1), state -> BLANK.
- FSM, two states:
  - BLANK, for cnt < BLANK_CYCLES: o_An = 5'b11111, o_Seg = OFF. Transition to ON when cnt reaches BLANK_CYCLES.
  - ON, for the remainder of the slot: o_An has bit idx low; o_Seg holds the snapshot[idx] value sampled at the BLANK->ON edge, stable for the whole ON phase.
  - If BLANK_CYCLES == 0, BLANK is skipped: the slot-boundary edge loads o_Seg/o_An for the new idx directly.
- Capture coincident with the BLANK->ON edge (or the slot boundary when BLANK_CYCLES = 0): the current slot shows the pre-capture value; the new value appears on the next visit to that digit.
- o_Digit_idx mirrors idx (registered, same edge as the idx update).
- o_Frame: high for exactly the one cycle following the 4->0 wrap edge; otherwise 0.
- Enable behaviour:
  - i_Enable low: on the next edge o_An = 5'b11111 and o_Seg = OFF. cnt and idx hold, o_Frame = 0, snapshot capture still works.
  - i_Enable rising: scan resumes at the same idx in BLANK with cnt = 0 (fresh full slot).
- Latency: input capture to visible on the segment bus = at most 5 slots plus the blank phase. No combinational path from any input to any output.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2 unless noted):
- Reset: drop i_Rst_n mid-ON at idx 3 between clock edges -> o_An=5'b11111, o_Seg=7'h7F, o_Digit_idx=0, o_Frame=0 immediately. After release, first ON begins on cycle 2.
- Scan order: capture 7'h01..7'h05 for first..fifth.
  - Slot 0: cycles 0-1 blank; cycles 2-7 o_An=5'b11110, o_Seg=7'h01.
  - Slot 1: o_An=5'b11101, o_Seg=7'h02, and so on through idx 4 (5'b01111 / 7'h05).
  - o_Frame pulses once, one cycle after cycle 39; idx returns to 0.
- No-capture isolation: change all inputs to 7'h40 with i_Capture=0 for 100 cycles -> o_Seg only ever shows 7'h01..7'h05 or 7'h7F.
- Enable: drop i_Enable at idx 2, cnt 4 for 10 cycles -> o_An=5'b11111 and o_Seg=7'h7F from the next edge. On re-raise: 2 blank cycles, then idx 2 ON for 6 cycles.
- Capture race: pulse i_Capture with first=7'h0F exactly at the BLANK->ON edge of idx 0 -> this slot shows 7'h01; the next idx-0 slot shows 7'h0F.
- BLANK_CYCLES=0, SEG_ACTIVE_LOW=0: o_An is never 5'b11111 after the first boundary. o_Seg changes only on slot edges, every 8 cycles. After reset o_Seg=7'h00.
